// File: rtl/dds_voice_scheduler.sv
// Round-robin scheduler that shares one note/pitch-to-DDS converter across all voices.
// Each voice's phase increment is stored in a per-voice slot that the DDS accumulators read directly.
module dds_voice_scheduler #(
    parameter int  VOICES   = 8,
    parameter int  CONV_LAT = 16,
    localparam int VW       = $clog2(VOICES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7*VOICES-1:0]  note_in,
    input  logic [VOICES-1:0]    gate_in,
    input  logic [13:0]          pitch_in,
    output logic [6:0]           conv_note,
    output logic [13:0]          conv_pitch,
    input  logic [31:0]          conv_adder,
    output logic [32*VOICES-1:0] adder_out,
    output logic                 upd_strobe,
    output logic [VW-1:0]        upd_voice,
    output logic                 sweep_done
);

    localparam int CW = $clog2(CONV_LAT + 1);

    typedef enum logic [1:0] {
        LOAD,
        WAIT,
        STORE
    } state_t;

    state_t         state;
    state_t         next_state;
    logic [VW-1:0]  vi;
    logic [CW-1:0]  wait_cnt;
    logic [6:0]     note_arr [VOICES];
    logic [31:0]    slot     [VOICES];
    logic           last_voice;
    logic           load_conv;
    logic           wr_en;
    logic [31:0]    wr_data;

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        assign note_arr[g]            = note_in[7*g +: 7];
        assign adder_out[32*g +: 32]  = slot[g];
    end

    // Wrap explicitly at VOICES-1 so non-power-of-2 voice counts never index a missing slot.
    assign last_voice = (vi == VW'(VOICES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    next_state = gate_in[vi] ? WAIT : LOAD;
            WAIT:    next_state = (wait_cnt == '0) ? STORE : WAIT;
            STORE:   next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // Ungated voices are cleared in their LOAD cycle without occupying the converter.
    always_comb begin
        load_conv = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        case (state)
            LOAD: begin
                if (gate_in[vi]) begin
                    load_conv = 1'b1;
                end else begin
                    wr_en = 1'b1;
                end
            end
            STORE: begin
                wr_en   = 1'b1;
                wr_data = conv_adder;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vi         <= '0;
            wait_cnt   <= '0;
            conv_note  <= '0;
            conv_pitch <= 14'd8192;
            upd_strobe <= 1'b0;
            upd_voice  <= '0;
            sweep_done <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                slot[i] <= '0;
            end
        end else begin
            upd_strobe <= wr_en;
            sweep_done <= wr_en && last_voice;
            if (wr_en) begin
                slot[vi]  <= wr_data;
                upd_voice <= vi;
                vi        <= last_voice ? '0 : vi + 1'b1;
            end
            if (load_conv) begin
                conv_note  <= note_arr[vi];
                conv_pitch <= pitch_in;
                wait_cnt   <= CW'(CONV_LAT - 1);
            end else if (state == WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dds_voice_scheduler.sv
// Directed bench for dds_voice_scheduler: an 8-voice/16-latency instance and a 3-voice/1-latency
// instance, each fed by a delay-line converter model, with strobe events logged per cycle.
module tb_dds_voice_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         rst_b_n;

    logic [55:0]  note_a;
    logic [7:0]   gate_a;
    logic [13:0]  pitch_a;
    logic [6:0]   conv_note_a;
    logic [13:0]  conv_pitch_a;
    logic [31:0]  conv_adder_a;
    logic [255:0] adder_a;
    logic         strobe_a;
    logic [2:0]   voice_a;
    logic         done_a;

    logic [20:0]  note_b;
    logic [2:0]   gate_b;
    logic [13:0]  pitch_b;
    logic [6:0]   conv_note_b;
    logic [13:0]  conv_pitch_b;
    logic [31:0]  conv_adder_b;
    logic [95:0]  adder_b;
    logic         strobe_b;
    logic [1:0]   voice_b;
    logic         done_b;

    dds_voice_scheduler #(.VOICES(8), .CONV_LAT(16)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .note_in    (note_a),
        .gate_in    (gate_a),
        .pitch_in   (pitch_a),
        .conv_note  (conv_note_a),
        .conv_pitch (conv_pitch_a),
        .conv_adder (conv_adder_a),
        .adder_out  (adder_a),
        .upd_strobe (strobe_a),
        .upd_voice  (voice_a),
        .sweep_done (done_a)
    );

    dds_voice_scheduler #(.VOICES(3), .CONV_LAT(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_b_n),
        .note_in    (note_b),
        .gate_in    (gate_b),
        .pitch_in   (pitch_b),
        .conv_note  (conv_note_b),
        .conv_pitch (conv_pitch_b),
        .conv_adder (conv_adder_b),
        .adder_out  (adder_b),
        .upd_strobe (strobe_b),
        .upd_voice  (voice_b),
        .sweep_done (done_b)
    );

    // Converter models: concatenated note/pitch delayed by CONV_LAT clocks.
    logic [31:0] pipe_a [16];
    always @(posedge clk) begin
        pipe_a[0] <= {11'd0, conv_note_a, conv_pitch_a};
        for (int i = 1; i < 16; i++) begin
            pipe_a[i] <= pipe_a[i-1];
        end
    end
    assign conv_adder_a = pipe_a[15];

    always @(posedge clk) begin
        conv_adder_b <= {11'd0, conv_note_b, conv_pitch_b};
    end

    int cyc_a;
    int cyc_b;
    always @(posedge clk) begin
        if (!rst_n) cyc_a <= 0; else cyc_a <= cyc_a + 1;
        if (!rst_b_n) cyc_b <= 0; else cyc_b <= cyc_b + 1;
    end

    typedef struct {
        int cyc;
        int voice;
        bit done;
    } ev_t;

    ev_t evq_a[$];
    ev_t evq_b[$];

    // Event index cyc = cycles since reset release in which the strobe is visible.
    always @(posedge clk) begin
        #1;
        if (strobe_a === 1'b1) evq_a.push_back('{cyc_a, int'(voice_a), done_a});
        if (strobe_b === 1'b1) evq_b.push_back('{cyc_b, int'(voice_b), done_b});
    end

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int base_note, input logic [7:0] gates, input logic [13:0] pitch);
        for (int v = 0; v < 8; v++) begin
            note_a[7*v +: 7] = 7'(base_note + v);
        end
        gate_a  = gates;
        pitch_a = pitch;
    endtask

    function automatic logic [31:0] conv(input int note, input int pitch);
        return {11'd0, 7'(note), 14'(pitch)};
    endfunction

    function automatic logic [31:0] slotA(input int v);
        return adder_a[32*v +: 32];
    endfunction

    function automatic logic [31:0] slotB(input int v);
        return adder_b[32*v +: 32];
    endfunction

    task automatic waitEventsA(input int n, input int budget);
        int k = 0;
        while (evq_a.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (evq_a.size() < n) checkOutput("timeout_events_a", 64'(evq_a.size()), 64'(n));
    endtask

    task automatic waitEventsB(input int n, input int budget);
        int k = 0;
        while (evq_b.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (evq_b.size() < n) checkOutput("timeout_events_b", 64'(evq_b.size()), 64'(n));
    endtask

    task automatic waitCycA(input int target, input int budget);
        int k = 0;
        while (cyc_a < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (cyc_a < target) checkOutput("timeout_cyc_a", 64'(cyc_a), 64'(target));
    endtask

    task automatic checkEventA(input string tag, input int idx, input int cyc, input int voice, input bit done);
        if (idx < evq_a.size()) begin
            checkOutput({tag, "_cyc"}, 64'(evq_a[idx].cyc), 64'(cyc));
            checkOutput({tag, "_voice"}, 64'(evq_a[idx].voice), 64'(voice));
            checkOutput({tag, "_done"}, 64'(evq_a[idx].done), 64'(done));
        end else begin
            checkOutput({tag, "_missing"}, 64'(evq_a.size()), 64'(idx + 1));
        end
    endtask

    int skip_off [8] = '{18, 19, 37, 38, 39, 40, 41, 42};

    initial begin
        int n0;
        int v5_count;

        rst_n   = 1'b0;
        rst_b_n = 1'b0;
        applyStimulus(60, 8'hFF, 14'd8192);
        note_b  = {7'd30, 7'd20, 7'd10};
        gate_b  = 3'b111;
        pitch_b = 14'd100;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_adder_any", 64'(|adder_a), 64'd0);
        checkOutput("rst_conv_pitch", 64'(conv_pitch_a), 64'd8192);
        checkOutput("rst_conv_note", 64'(conv_note_a), 64'd0);
        checkOutput("rst_strobe", 64'(strobe_a), 64'd0);
        checkOutput("rst_voice", 64'(voice_a), 64'd0);
        checkOutput("rst_done", 64'(done_a), 64'd0);
        checkOutput("rst_no_events", 64'(evq_a.size()), 64'd0);

        // Full sweep, all gated
        rst_n = 1'b1;
        evq_a.delete();
        waitEventsA(1, 40);
        checkEventA("first_strobe", 0, 18, 0, 1'b0);
        waitEventsA(8, 200);
        for (int i = 0; i < 8; i++) begin
            checkEventA($sformatf("sweep_ev%0d", i), i, 18*(i+1), i, i == 7);
        end
        for (int v = 0; v < 8; v++) begin
            checkOutput($sformatf("sweep_slot%0d", v), 64'(slotA(v)), 64'(conv(60 + v, 8192)));
        end

        // Gate skip, continuing straight into the next sweep at cycle 144
        applyStimulus(60, 8'b0000_0101, 14'd8192);
        waitEventsA(16, 120);
        for (int i = 0; i < 8; i++) begin
            checkEventA($sformatf("skip_ev%0d", i), 8 + i, 144 + skip_off[i], i, i == 7);
        end
        for (int v = 0; v < 8; v++) begin
            checkOutput($sformatf("skip_slot%0d", v), 64'(slotA(v)),
                        (v == 0 || v == 2) ? 64'(conv(60 + v, 8192)) : 64'd0);
        end

        // Snapshot: pitch changes during voice 3's WAIT
        rst_n = 1'b0;
        applyStimulus(66, 8'b0000_1000, 14'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        evq_a.delete();
        waitCycA(10, 40);
        pitch_a = 14'd16383;
        waitEventsA(4, 60);
        checkEventA("snap_v3", 3, 21, 3, 1'b0);
        checkOutput("snap_slot3_old", 64'(slotA(3)), 64'(conv(69, 0)));
        waitEventsA(12, 100);
        checkEventA("snap_v3_next", 11, 46, 3, 1'b0);
        checkOutput("snap_slot3_new", 64'(slotA(3)), 64'(conv(69, 16383)));
        checkOutput("snap_conv_pitch", 64'(conv_pitch_a), 64'd16383);

        // Reset in the middle of voice 5's WAIT
        rst_n = 1'b0;
        applyStimulus(60, 8'hFF, 14'd8192);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        evq_a.delete();
        waitCycA(95, 200);
        checkOutput("midrst_pre_events", 64'(evq_a.size()), 64'd5);
        checkOutput("midrst_pre_slot4", 64'(slotA(4)), 64'(conv(64, 8192)));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int v = 0; v < 8; v++) begin
            checkOutput($sformatf("midrst_slot%0d", v), 64'(slotA(v)), 64'd0);
        end
        checkOutput("midrst_strobe", 64'(strobe_a), 64'd0);
        rst_n = 1'b1;
        n0 = evq_a.size();
        waitEventsA(n0 + 1, 40);
        checkEventA("midrst_restart", n0, 18, 0, 1'b0);
        v5_count = 0;
        foreach (evq_a[i]) begin
            if (evq_a[i].voice == 5) v5_count++;
        end
        checkOutput("midrst_no_v5", 64'(v5_count), 64'd0);

        // 3-voice instance, CONV_LAT=1: wrap at VOICES-1
        rst_b_n = 1'b1;
        evq_b.delete();
        waitEventsB(7, 60);
        for (int i = 0; i < 7; i++) begin
            if (i < evq_b.size()) begin
                checkOutput($sformatf("wrap_ev%0d_cyc", i), 64'(evq_b[i].cyc), 64'(3*(i+1)));
                checkOutput($sformatf("wrap_ev%0d_voice", i), 64'(evq_b[i].voice), 64'(i % 3));
                checkOutput($sformatf("wrap_ev%0d_done", i), 64'(evq_b[i].done), 64'(i % 3 == 2));
            end
        end
        for (int v = 0; v < 3; v++) begin
            checkOutput($sformatf("wrap_slot%0d", v), 64'(slotB(v)), 64'(conv(10*(v+1), 100)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_voice_scheduler.md
# dds_voice_scheduler

Time-shares a single `note_pitch2dds` converter among `VOICES` synth voices. A round-robin sweep presents each gated voice's note and the global pitch-bend word to the converter, waits out its settling latency, and latches the resulting 32-bit DDS phase increment into a per-voice register bank. The block sits between the MIDI/voice-allocation logic and the per-voice DDS phase accumulators, which read `adder_out` continuously.

## Interface
- `VOICES`, 8: number of voices; ≥2.
- `CONV_LAT`, 16: cycles the converter needs after its inputs change before `conv_adder` is valid; ≥1.
- `VW`, `$clog2(VOICES)`: voice index width (derived, not overridden).

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `note_in` in 7*VOICES: voice v note at `[7v+6:7v]`.
- `gate_in` in VOICES: voice active flags.
- `pitch_in` in 14: global pitch bend; 8192 is centre.
- `conv_note` out 7: to converter note input (registered).
- `conv_pitch` out 14: to converter pitch input (registered).
- `conv_adder` in 32: converter result.
- `adder_out` out 32*VOICES: voice v increment at `[32v+31:32v]`.
- `upd_strobe` out 1: one-cycle pulse when a slot is written.
- `upd_voice` out VW: slot index written; valid with `upd_strobe`.
- `sweep_done` out 1: one-cycle pulse coincident with the write of voice VOICES-1.

## Operation
- FSM states: LOAD, WAIT, STORE. The voice index `vi` is a VW-bit counter.
- LOAD:
  - If `gate_in[vi]`=1: register `conv_note`←`note_in[vi]` and `conv_pitch`←`pitch_in`, load the wait counter with CONV_LAT-1, then go to WAIT.
  - If `gate_in[vi]`=0: write 0 to slot `vi`, pulse `upd_strobe` with `upd_voice`=`vi`, advance `vi`, and stay in LOAD. `conv_*` hold their values.
- WAIT: decrement the counter. When it reaches 0, go to STORE. CONV_LAT=1 gives exactly one WAIT cycle.
- STORE: write `conv_adder` into slot `vi`, pulse `upd_strobe`/`upd_voice`, advance `vi`, go to LOAD.
- Advance rule: `vi`=VOICES-1 wraps to 0 and `sweep_done` pulses in the same cycle as that write. For non-power-of-2 VOICES, wrap at VOICES-1, not at 2^VW-1.
- Sampling:
  - `note_in` and `pitch_in` are snapshotted in LOAD only. Changes during WAIT/STORE take effect on that voice's next visit.
  - `gate_in[vi]` is sampled in LOAD only. A gate drop mid-conversion still stores the converted value; the slot clears on the next sweep.
- Untouched slots hold their value. Only slot `vi` changes on a write.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - All `adder_out` slots 0; `conv_note`=0; `conv_pitch`=8192; `upd_strobe`=0; `upd_voice`=0; `sweep_done`=0.
  - `vi`=0, state LOAD, wait counter 0.
  - Reset mid-sweep abandons the conversion in progress; nothing is stored.
- Gated voice: LOAD at cycle t. New `conv_*` are visible from t+1. STORE is at t+CONV_LAT+1, with the slot and strobe visible at t+CONV_LAT+2. Cost: CONV_LAT+2 cycles per voice.
- Ungated voice: 1 cycle (the LOAD cycle).
- Sweep period = Σ over voices of (gated ? CONV_LAT+2 : 1).
- First `upd_strobe` after reset release: cycle CONV_LAT+2 if voice 0 is gated; otherwise cycle 1.
- `upd_strobe` never asserts on two consecutive cycles unless the voices involved are ungated.

## Test plan
- Bench converter model: `conv_adder` = {11'd0, conv_note, conv_pitch}, delayed CONV_LAT cycles. VOICES=8, CONV_LAT=16.
- Reset values: hold `rst_n`=0 for 3 cycles, all gates 1 → `adder_out`=0, `conv_pitch`=8192, no strobes. After release, the first strobe arrives at cycle 18 with `upd_voice`=0.
- Full sweep: notes 60..67, pitch 8192, all gated → slot v = {11'd0, 60+v, 14'd8192}. 8 strobes spaced 18 cycles apart; `sweep_done` coincides with voice 7.
- Gate skip: gates 8'b0000_0101 → only slots 0 and 2 are non-zero. Other slots are written 0 on single-cycle strobes. Sweep period = 2·18+6 = 42 cycles.
- Snapshot: voice 3 note 69, pitch 0. Change pitch to 16383 during voice 3's WAIT → slot 3 = {11'd0, 7'd69, 14'd0}. The next sweep gives pitch 16383.
- Reset mid-WAIT on voice 5 after slots 0–4 are filled → all slots 0 and `vi`=0. No strobe for voice 5 is emitted.
- Wrap with VOICES=3, CONV_LAT=1 → `upd_voice` sequence 0,1,2,0, each 3 cycles apart. `sweep_done` pulses on every third strobe, and `vi` never reaches 3.
